// File: rtl/sofm_pkg.sv
// sofm_pkg: shared state type and map defaults for the SOFM update sequencer
package sofm_pkg;
  typedef enum logic [2:0] {IDLE, RD, AD, WR, DONE} state_t;
  localparam int MAP_W_DEF = 100;
  localparam int MAP_H_DEF = 100;
  localparam int DIM_DEF = 3;
  localparam int ALPHA_W = 16;
endpackage

// File: rtl/sofm_nbr_walker.sv
// sofm_nbr_walker: clipped neighbourhood bounds, y/x/ch walk counters, RAM address and Chebyshev distance
module sofm_nbr_walker import sofm_pkg::*; #(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int DIM = DIM_DEF,
  parameter int AW = 15,
  parameter int CW = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [7:0]    wx_in,
  input  logic [7:0]    wy_in,
  input  logic [7:0]    r_in,
  output logic [7:0]    x,
  output logic [7:0]    y,
  output logic [CW-1:0] ch,
  output logic          last,
  output logic [AW-1:0] addr,
  output logic [7:0]    d
);
  localparam logic [8:0] XM = 9'(MAP_W - 1);
  localparam logic [8:0] YM = 9'(MAP_H - 1);
  localparam logic [CW-1:0] CL = CW'(DIM - 1);
  logic [8:0] r9, wxc, wyc, xlo, ylo, xhi, yhi;
  logic [7:0] wx, wy, xmin, xmax, ymax, dx, dy;
  logic lx, ly, lc;
  always_comb begin
    r9 = {1'b0, r_in};
    wxc = ({1'b0, wx_in} > XM) ? XM : {1'b0, wx_in};
    wyc = ({1'b0, wy_in} > YM) ? YM : {1'b0, wy_in};
    xlo = (wxc >= r9) ? wxc - r9 : 9'd0;
    ylo = (wyc >= r9) ? wyc - r9 : 9'd0;
    xhi = (wxc + r9 > XM) ? XM : wxc + r9;
    yhi = (wyc + r9 > YM) ? YM : wyc + r9;
  end
  always_ff @(posedge clk)
    if (rst) begin
      {wx, wy, xmin, xmax, ymax, x, y} <= '0;
      ch <= '0;
    end else if (load) begin
      wx <= wxc[7:0];
      wy <= wyc[7:0];
      xmin <= xlo[7:0];
      xmax <= xhi[7:0];
      ymax <= yhi[7:0];
      x <= xlo[7:0];
      y <= ylo[7:0];
      ch <= '0;
    end else if (adv && !last) begin
      ch <= lc ? '0 : ch + 1'b1;
      if (lc) x <= lx ? xmin : x + 8'd1;
      if (lc && lx) y <= y + 8'd1;
    end
  assign lc = ch == CL;
  assign lx = x == xmax;
  assign ly = y == ymax;
  assign last = lc && lx && ly;
  assign dx = (x >= wx) ? x - wx : wx - x;
  assign dy = (y >= wy) ? y - wy : wy - y;
  assign d = (dx > dy) ? dx : dy;
  assign addr = AW'((32'(y) * MAP_W + 32'(x)) * DIM + 32'(ch));
endmodule

// File: rtl/sofm_update_ctrl.sv
// sofm_update_ctrl: sequences read/adapt/write of every weight byte in the winner's clipped neighbourhood
module sofm_update_ctrl import sofm_pkg::*; #(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int DIM = DIM_DEF,
  parameter int AW = 15,
  parameter int CW = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [7:0]         i_wx,
  input  logic [7:0]         i_wy,
  input  logic [7:0]         i_radius,
  input  logic [ALPHA_W-1:0] i_alpha,
  output logic               o_busy,
  output logic               o_done,
  output logic [CW-1:0]      o_ch,
  input  logic [7:0]         i_xi,
  output logic [AW-1:0]      o_mem_addr,
  output logic               o_mem_re,
  input  logic [7:0]         i_mem_rdata,
  output logic               o_mem_we,
  output logic [7:0]         o_mem_wdata,
  output logic [7:0]         o_ad_data,
  output logic [7:0]         o_ad_xi,
  output logic [ALPHA_W-1:0] o_ad_alpha,
  output logic               o_ad_update,
  output logic [15:0]        o_ad_pos,
  input  logic [7:0]         i_ad_mi
);
  state_t state, nxt;
  logic [ALPHA_W-1:0] alpha;
  logic [7:0] x, y, d;
  logic last, load;
  assign load = state == IDLE && i_start;
  sofm_nbr_walker #(.MAP_W(MAP_W), .MAP_H(MAP_H), .DIM(DIM), .AW(AW), .CW(CW)) walker (
    .clk(i_clk), .rst(i_rst), .load(load), .adv(state == WR),
    .wx_in(i_wx), .wy_in(i_wy), .r_in(i_radius),
    .x(x), .y(y), .ch(o_ch), .last(last), .addr(o_mem_addr), .d(d)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      alpha <= '0;
      o_mem_wdata <= '0;
    end else begin
      state <= nxt;
      if (load) alpha <= i_alpha;
      if (state == AD) o_mem_wdata <= i_ad_mi;
    end
  always_comb begin
    nxt = (state == IDLE) ? (i_start ? RD : IDLE) :
          (state == RD)   ? AD :
          (state == AD)   ? WR :
          (state == WR)   ? (last ? DONE : RD) : IDLE;
  end
  // strobes are gated by reset so a WR cycle hit by reset never commits its byte
  assign o_mem_re = state == RD && !i_rst;
  assign o_mem_we = state == WR && !i_rst;
  assign o_busy = state == RD || state == AD || state == WR;
  assign o_done = state == DONE;
  assign o_ad_update = state == AD;
  assign o_ad_data = i_mem_rdata;
  assign o_ad_xi = i_xi;
  assign o_ad_pos = {y, x};
  assign o_ad_alpha = (d >= 8'd16) ? '0 : alpha >> d;
endmodule

// File: tb/tb_sofm_update_ctrl.sv
// tb_sofm_update_ctrl: randomized scoreboard bench with a loop-based neighbourhood reference model
module tb_sofm_update_ctrl;
  localparam int MW = 100, MH = 100, DM = 3, AW = 15;
  logic clk = 0, i_rst = 1, i_start = 0;
  logic [7:0] i_wx = 0, i_wy = 0, i_radius = 0, i_xi, i_mem_rdata = 0, i_ad_mi;
  logic [15:0] i_alpha = 0;
  logic o_busy, o_done, o_mem_re, o_mem_we, o_ad_update;
  logic [1:0] o_ch;
  logic [AW-1:0] o_mem_addr;
  logic [7:0] o_mem_wdata, o_ad_data, o_ad_xi;
  logic [15:0] o_ad_alpha, o_ad_pos;
  int checks = 0, errors = 0, cyc = 0, n_wr = 0, first_addr = -1;
  logic [7:0] mem [0:32767];
  logic [7:0] mem_ref [0:32767];
  logic [7:0] sample [0:2];
  typedef struct {int addr; logic [7:0] data; logic [7:0] old;} wr_t;
  typedef struct {int pos; int alpha;} ad_t;
  wr_t exp_q[$];
  ad_t ad_q[$];
  wr_t ew, last_wr;
  ad_t ea;

  sofm_update_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_wx(i_wx), .i_wy(i_wy),
    .i_radius(i_radius), .i_alpha(i_alpha), .o_busy(o_busy), .o_done(o_done),
    .o_ch(o_ch), .i_xi(i_xi), .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_ad_data(o_ad_data), .o_ad_xi(o_ad_xi), .o_ad_alpha(o_ad_alpha),
    .o_ad_update(o_ad_update), .o_ad_pos(o_ad_pos), .i_ad_mi(i_ad_mi)
  );

  function automatic logic [7:0] adapt(logic [7:0] w, logic [7:0] xi, logic [15:0] a);
    int diff;
    diff = int'(xi) - int'(w);
    return 8'(int'(w) + ((diff * int'(a)) >>> 16));
  endfunction

  assign i_ad_mi = adapt(o_ad_data, o_ad_xi, o_ad_alpha);
  assign i_xi = (o_ch < 2'd3) ? sample[o_ch] : 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) if (!i_rst) begin
    if (o_mem_re && o_mem_we) chk("re_we_exclusive", 1, 0);
    if (o_ad_update) begin
      if (ad_q.size() == 0) chk("unexpected_adapt", 1, 0);
      else begin
        ea = ad_q.pop_front();
        chk("ad_alpha", int'(o_ad_alpha), ea.alpha);
        chk("ad_pos", int'(o_ad_pos), ea.pos);
      end
    end
    if (o_mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        ew = exp_q.pop_front();
        chk("wr_addr", int'(o_mem_addr), ew.addr);
        chk("wr_data", int'(o_mem_wdata), int'(ew.data));
        if (n_wr == 0) first_addr = int'(o_mem_addr);
        last_wr = ew;
        n_wr++;
      end
    end
  end

  // reference: enumerate the clipped square directly and apply the adapter byte by byte
  task automatic plan(input int wx, input int wy, input int r, input logic [15:0] a, output int n);
    int cx, cy, dd, addr;
    logic [15:0] al;
    logic [7:0] nw;
    cx = (wx > MW - 1) ? MW - 1 : wx;
    cy = (wy > MH - 1) ? MH - 1 : wy;
    n = 0;
    for (int yy = (cy - r < 0 ? 0 : cy - r); yy <= (cy + r > MH - 1 ? MH - 1 : cy + r); yy++)
      for (int xx = (cx - r < 0 ? 0 : cx - r); xx <= (cx + r > MW - 1 ? MW - 1 : cx + r); xx++) begin
        dd = (xx > cx ? xx - cx : cx - xx);
        if ((yy > cy ? yy - cy : cy - yy) > dd) dd = (yy > cy ? yy - cy : cy - yy);
        al = (dd >= 16) ? 16'h0 : a >> dd;
        for (int c = 0; c < DM; c++) begin
          addr = (yy * MW + xx) * DM + c;
          nw = adapt(mem_ref[addr], sample[c], al);
          ad_q.push_back('{pos: yy * 256 + xx, alpha: int'(al)});
          exp_q.push_back('{addr: addr, data: nw, old: mem_ref[addr]});
          mem_ref[addr] = nw;
          n++;
        end
      end
  endtask

  task automatic run(input int wx, input int wy, input int r, input logic [15:0] a, input int poke);
    int n, t0, t_done;
    bit seen;
    for (int c = 0; c < DM; c++) sample[c] = 8'($urandom);
    n_wr = 0;
    plan(wx, wy, r, a, n);
    @(negedge clk);
    i_wx = 8'(wx); i_wy = 8'(wy); i_radius = 8'(r); i_alpha = a; i_start = 1;
    t0 = cyc;
    @(negedge clk);
    seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      i_start = (k == poke);
      if (k == poke) begin
        i_wx = 8'($urandom); i_wy = 8'($urandom); i_radius = 8'($urandom); i_alpha = 16'($urandom);
      end
      if (o_done) begin
        seen = 1;
        t_done = cyc;
      end else @(negedge clk);
    end
    i_start = 0;
    chk("done_seen", int'(seen), 1);
    if (seen) chk("done_cycle", t_done - t0, 3 * n + 1);
    chk("write_count", n_wr, n);
    @(negedge clk);
    chk("done_pulse", int'(o_done), 0);
    chk("busy_idle", int'(o_busy), 0);
    chk("queue_empty", exp_q.size() + ad_q.size(), 0);
    exp_q.delete();
    ad_q.delete();
  endtask

  initial begin
    int n, cnt, diffs;
    wr_t saved;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'($urandom);
      mem_ref[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_re", int'(o_mem_re), 0);
    chk("rst_we", int'(o_mem_we), 0);
    chk("rst_update", int'(o_ad_update), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_wdata", int'(o_mem_wdata), 0);
    chk("rst_ch", int'(o_ch), 0);
    i_rst = 0;
    run(5, 5, 1, 16'h8000, -1);
    run(0, 0, 2, 16'h6000, -1);
    chk("corner_first_addr", first_addr, 0);
    run(99, 99, 3, 16'hA000, -1);
    chk("edge_last_addr", last_wr.addr, 9999 * DM + DM - 1);
    run(200, 7, 0, 16'hFFFF, -1);
    chk("r0_first_addr", first_addr, (7 * MW + 99) * DM);
    run(40, 60, 2, 16'h3000, 7);
    run(50, 50, 20, 16'hC000, -1);
    for (int t = 0; t < 6; t++)
      run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 16'($urandom), $urandom_range(1, 5));
    for (int c = 0; c < DM; c++) sample[c] = 8'($urandom);
    n_wr = 0;
    plan(30, 30, 2, 16'h8000, n);
    @(negedge clk);
    i_wx = 30; i_wy = 30; i_radius = 2; i_alpha = 16'h8000; i_start = 1;
    @(negedge clk);
    i_start = 0;
    cnt = 0;
    for (int k = 0; k < 1000 && cnt < 5; k++) begin
      @(negedge clk);
      #1;
      if (o_mem_we) cnt++;
    end
    chk("rst_reached_wr", cnt, 5);
    i_rst = 1;
    saved = last_wr;
    @(negedge clk);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_done", int'(o_done), 0);
    chk("abort_no_write", int'(mem[saved.addr]), int'(saved.old));
    chk("abort_addr", int'(o_mem_addr), 0);
    chk("abort_wdata", int'(o_mem_wdata), 0);
    i_rst = 0;
    mem_ref[saved.addr] = saved.old;
    foreach (exp_q[i]) mem_ref[exp_q[i].addr] = exp_q[i].old;
    exp_q.delete();
    ad_q.delete();
    run(10, 90, 1, 16'h4000, -1);
    diffs = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== mem_ref[i]) diffs++;
    chk("mem_final", diffs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
